// File: rtl/fmap_window_streamer.sv
`default_nettype none
// ============================================================================
// Module   : fmap_window_streamer
// Purpose  : Streams KSIZE-row column vectors of CH stored feature maps into
//            the next conv layer through a credit-tracked output FIFO.
//            Optional zero row padding: define FMAP_STREAM_PAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fmap_window_streamer #(
    parameter int DATA_WIDTH = 22,
    parameter int CH         = 3,
    parameter int KSIZE      = 3,
    parameter int IMG_W      = 222,
    parameter int IMG_H      = 222,
    parameter int ADDR_WIDTH = 18,
    parameter int RD_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           rd_en,
    output logic [KSIZE*ADDR_WIDTH-1:0]    rd_addr,
    input  logic [CH*KSIZE*DATA_WIDTH-1:0] rd_data,
    output logic [CH*KSIZE*DATA_WIDTH-1:0] out_col,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ADDR_WIDTH-1:0]          out_row,
    output logic [ADDR_WIDTH-1:0]          out_x
);
    localparam int VW    = CH * KSIZE * DATA_WIDTH;
    localparam int DEPTH = RD_LATENCY + 2;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef FMAP_STREAM_PAD_EN
    localparam int PAD   = (KSIZE - 1) / 2;
    localparam int ROWS  = IMG_H;
`else
    localparam int PAD   = 0;
    localparam int ROWS  = IMG_H - KSIZE + 1;
`endif
    localparam logic [ADDR_WIDTH-1:0] W_STEP   = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] LAST_X   = ADDR_WIDTH'(IMG_W - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    function automatic logic [ADDR_WIDTH-1:0] base_init(input int k);
        return ADDR_WIDTH'((k - PAD) * IMG_W);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] x_q, x_d, row_q, row_d;
    logic [ADDR_WIDTH-1:0] rb_q [KSIZE];
    logic [ADDR_WIDTH-1:0] rb_d [KSIZE];
    logic [RD_LATENCY-1:0] sr_q;
    logic [ADDR_WIDTH-1:0] prow_q [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] px_q   [RD_LATENCY];
    logic [VW-1:0]         mem_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] mrow_q [DEPTH];
    logic [ADDR_WIDTH-1:0] mx_q   [DEPTH];
    logic [PW-1:0]         wp_q, rp_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         w_inflight;
    logic [CW:0]           w_used;
    logic                  w_push, w_pop, w_last;
    logic [VW-1:0]         w_push_data;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + CW'(sr_q[i]);
        end
    end

    // Credit covers both buffered vectors and reads whose data is still in the memory pipe.
    assign w_used    = {1'b0, cnt_q} + {1'b0, w_inflight};
    assign rd_en     = (state_q == S_RUN) && (w_used < (CW+1)'(DEPTH));
    assign w_last    = (x_q == LAST_X) && (row_q == LAST_ROW);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (cnt_q != '0);
    assign w_push    = sr_q[RD_LATENCY-1];
    assign w_pop     = out_valid && out_ready;
    assign out_col   = mem_q[rp_q];
    assign out_row   = mrow_q[rp_q];
    assign out_x     = mx_q[rp_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (rd_en && w_last) state_d = S_DRAIN;
            S_DRAIN: begin
                if ((cnt_q == '0) && (w_inflight == '0)) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        x_d   = x_q;
        row_d = row_q;
        for (int k = 0; k < KSIZE; k++) rb_d[k] = rb_q[k];
        if (state_q == S_IDLE) begin
            x_d   = '0;
            row_d = '0;
            for (int k = 0; k < KSIZE; k++) rb_d[k] = base_init(k);
        end else if (rd_en) begin
            if (x_q == LAST_X) begin
                x_d   = '0;
                row_d = row_q + ADDR_WIDTH'(1);
                for (int k = 0; k < KSIZE; k++) rb_d[k] = rb_q[k] + W_STEP;
            end else begin
                x_d = x_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            row_q <= '0;
            for (int k = 0; k < KSIZE; k++) rb_q[k] <= base_init(k);
        end else begin
            x_q   <= x_d;
            row_q <= row_d;
            for (int k = 0; k < KSIZE; k++) rb_q[k] <= rb_d[k];
        end
    end

    for (genvar k = 0; k < KSIZE; k++) begin : g_addr
        assign rd_addr[(KSIZE-1-k)*ADDR_WIDTH +: ADDR_WIDTH] = rb_q[k] + x_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                prow_q[i] <= '0;
                px_q[i]   <= '0;
            end
        end else begin
            sr_q[0]   <= rd_en;
            prow_q[0] <= row_q;
            px_q[0]   <= x_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                sr_q[i]   <= sr_q[i-1];
                prow_q[i] <= prow_q[i-1];
                px_q[i]   <= px_q[i-1];
            end
        end
    end

`ifdef FMAP_STREAM_PAD_EN
    logic [KSIZE-1:0] w_pad;
    logic [KSIZE-1:0] ppad_q [RD_LATENCY];

    always_comb begin
        w_pad = '0;
        for (int k = 0; k < KSIZE; k++) begin
            w_pad[k] = ((int'(row_q) + k - PAD) < 0) || ((int'(row_q) + k - PAD) >= IMG_H);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) ppad_q[i] <= '0;
        end else begin
            ppad_q[0] <= w_pad;
            for (int i = 1; i < RD_LATENCY; i++) ppad_q[i] <= ppad_q[i-1];
        end
    end

    // Padded slots still read memory; their returned data is replaced by zero here.
    always_comb begin
        w_push_data = rd_data;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < KSIZE; k++) begin
                if (ppad_q[RD_LATENCY-1][k]) begin
                    w_push_data[(CH*KSIZE-1-(c*KSIZE+k))*DATA_WIDTH +: DATA_WIDTH] = '0;
                end
            end
        end
    end
`else
    assign w_push_data = rd_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i]  <= '0;
                mrow_q[i] <= '0;
                mx_q[i]   <= '0;
            end
        end else begin
            if (w_push) begin
                mem_q[wp_q]  <= w_push_data;
                mrow_q[wp_q] <= prow_q[RD_LATENCY-1];
                mx_q[wp_q]   <= px_q[RD_LATENCY-1];
                wp_q         <= ptr_inc(wp_q);
            end
            if (w_pop) begin
                rp_q <= ptr_inc(rp_q);
            end
            case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fmap_window_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmap_window_streamer
// Purpose  : Scoreboard bench for fmap_window_streamer; two instances run
//            side by side with read latencies 1 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmap_window_streamer;
    localparam int DW    = 8;
    localparam int CH    = 2;
    localparam int KSIZE = 3;
    localparam int IMG_W = 4;
    localparam int IMG_H = 5;
    localparam int AW    = 10;
    localparam int LAT0  = 1;
    localparam int LAT1  = 3;
    localparam int VW    = CH * KSIZE * DW;
`ifdef FMAP_STREAM_PAD_EN
    localparam int PAD   = (KSIZE - 1) / 2;
    localparam int ROWS  = IMG_H;
`else
    localparam int PAD   = 0;
    localparam int ROWS  = IMG_H - KSIZE + 1;
`endif
    localparam int NV    = ROWS * IMG_W;

    typedef struct packed {
        logic [VW-1:0] col;
        logic [AW-1:0] row;
        logic [AW-1:0] x;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, out_ready;
    logic busy0, done0, rd_en0, ov0, busy1, done1, rd_en1, ov1;
    logic [KSIZE*AW-1:0] rd_addr0, rd_addr1;
    logic [VW-1:0] rd_data0, rd_data1, col0, col1;
    logic [AW-1:0] row0, row1, x0, x1;

    int   cyc = 0;
    int   t0 = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    int   acc[2], issued[2], first_v[2], last_acc[2], done_n[2], done_cyc[2];
    exp_t q0[$];
    exp_t q1[$];
    logic [3:0] rdy_pat = 4'b1001;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fmap_window_streamer #(
        .DATA_WIDTH(DW), .CH(CH), .KSIZE(KSIZE), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .ADDR_WIDTH(AW), .RD_LATENCY(LAT0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
        .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0), .out_col(col0),
        .out_valid(ov0), .out_ready(out_ready), .out_row(row0), .out_x(x0)
    );

    fmap_window_streamer #(
        .DATA_WIDTH(DW), .CH(CH), .KSIZE(KSIZE), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .ADDR_WIDTH(AW), .RD_LATENCY(LAT1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1), .out_col(col1),
        .out_valid(ov1), .out_ready(out_ready), .out_row(row1), .out_x(x1)
    );

    // Memory model: channel c returns (addr + 16c) mod 256, RD_LATENCY cycles after the address.
    function automatic logic [VW-1:0] mem_word(input logic [KSIZE*AW-1:0] a);
        logic [VW-1:0] v;
        logic [AW-1:0] ad;
        v = '0;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < KSIZE; k++) begin
                ad = a[(KSIZE-1-k)*AW +: AW];
                v[(CH*KSIZE-1-(c*KSIZE+k))*DW +: DW] = DW'((int'(ad) + 16*c) % 256);
            end
        end
        return v;
    endfunction

    logic [KSIZE*AW-1:0] ap0 [LAT0];
    logic [KSIZE*AW-1:0] ap1 [LAT1];
    always @(posedge clk) begin
        ap0[0] <= rd_addr0;
        ap1[0] <= rd_addr1;
        for (int i = 1; i < LAT1; i++) ap1[i] <= ap1[i-1];
    end
    assign rd_data0 = mem_word(ap0[LAT0-1]);
    assign rd_data1 = mem_word(ap1[LAT1-1]);

    function automatic logic [VW-1:0] exp_col(input int r, input int x);
        logic [VW-1:0] v;
        int mr;
        int val;
        v = '0;
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < KSIZE; k++) begin
                mr  = r + k - PAD;
                val = (mr < 0 || mr >= IMG_H) ? 0 : ((mr * IMG_W + x + 16 * c) % 256);
                v[(CH*KSIZE-1-(c*KSIZE+k))*DW +: DW] = DW'(val);
            end
        end
        return v;
    endfunction

    function automatic logic [KSIZE*AW-1:0] exp_reset_addr();
        logic [KSIZE*AW-1:0] a;
        a = '0;
        for (int k = 0; k < KSIZE; k++) a[(KSIZE-1-k)*AW +: AW] = AW'((k - PAD) * IMG_W);
        return a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic clear();
        for (int d = 0; d < 2; d++) begin
            acc[d] = 0; issued[d] = 0; first_v[d] = -1;
            last_acc[d] = -1; done_n[d] = 0; done_cyc[d] = -1;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic push_exp();
        exp_t e;
        for (int r = 0; r < ROWS; r++) begin
            for (int x = 0; x < IMG_W; x++) begin
                e.col = exp_col(r, x);
                e.row = AW'(r);
                e.x   = AW'(x);
                q0.push_back(e);
                q1.push_back(e);
            end
        end
    endtask

    task automatic mon(input int d, input logic v, input logic [VW-1:0] col,
                       input logic [AW-1:0] row, input logic [AW-1:0] x,
                       input logic dn, input logic re);
        exp_t e;
        int   qs;
        int   depth;
        if (rst) return;
        depth = ((d == 0) ? LAT0 : LAT1) + 2;
        if (re) begin
            issued[d]++;
            chk("credit_bound", 64'((issued[d] - acc[d]) <= depth), 64'd1);
        end
        if (v) begin
            if (first_v[d] < 0) first_v[d] = cyc - t0;
            qs = (d == 0) ? q0.size() : q1.size();
            chk("vec_expected", 64'(qs != 0), 64'd1);
            if (qs != 0) begin
                e = (d == 0) ? q0[0] : q1[0];
                chk("out_col", 64'(col), 64'(e.col));
                chk("out_row", 64'(row), 64'(e.row));
                chk("out_x", 64'(x), 64'(e.x));
                if (out_ready) begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    acc[d]++;
                    last_acc[d] = cyc - t0;
                end
            end
        end
        if (dn) begin
            done_n[d]++;
            if (done_n[d] == 1) done_cyc[d] = cyc - t0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, ov0, col0, row0, x0, done0, rd_en0);
        mon(1, ov1, col1, row1, x1, done1, rd_en1);
    end

    task automatic end_checks(input bit timing);
        chk("dut0_count", 64'(acc[0]), 64'(NV));
        chk("dut1_count", 64'(acc[1]), 64'(NV));
        chk("dut0_done_n", 64'(done_n[0]), 64'd1);
        chk("dut1_done_n", 64'(done_n[1]), 64'd1);
        chk("dut0_q_left", 64'(q0.size()), 64'd0);
        chk("dut1_q_left", 64'(q1.size()), 64'd0);
        chk("dut0_idle", 64'(busy0), 64'd0);
        chk("dut1_idle", 64'(busy1), 64'd0);
        if (timing) begin
            chk("dut0_first_valid", 64'(first_v[0]), 64'(1 + LAT0 + 1));
            chk("dut1_first_valid", 64'(first_v[1]), 64'(1 + LAT1 + 1));
            chk("dut0_done_cyc", 64'(done_cyc[0]), 64'(NV + LAT0 + 2));
            chk("dut1_done_cyc", 64'(done_cyc[1]), 64'(NV + LAT1 + 2));
            chk("dut0_no_bubble", 64'(last_acc[0] - first_v[0]), 64'(NV - 1));
            chk("dut1_no_bubble", 64'(last_acc[1] - first_v[1]), 64'(NV - 1));
        end
    endtask

    task automatic run(input bit bp, input int s2a, input int s2b, input bit timing);
        clear();
        push_exp();
        start     = 1'b1;
        out_ready = 1'b1;
        t0        = cyc;
        for (int c = 1; c <= 90; c++) begin
            @(posedge clk); #1;
            start     = (c == s2a) || (c == s2b);
            out_ready = bp ? rdy_pat[c % 4] : 1'b1;
        end
        out_ready = 1'b1;
        end_checks(timing);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy0", 64'(busy0), 64'd0);
        chk("rst_done0", 64'(done0), 64'd0);
        chk("rst_rd_en0", 64'(rd_en0), 64'd0);
        chk("rst_valid0", 64'(ov0), 64'd0);
        chk("rst_rd_addr0", 64'(rd_addr0), 64'(exp_reset_addr()));
        chk("rst_col0", 64'(col0), 64'd0);
        chk("rst_row0", 64'(row0), 64'd0);
        chk("rst_x0", 64'(x0), 64'd0);
        chk("rst_valid1", 64'(ov1), 64'd0);
        chk("rst_rd_addr1", 64'(rd_addr1), 64'(exp_reset_addr()));
        rst = 1'b0;

        run(1'b0, -1, -1, 1'b1);
        run(1'b1, -1, -1, 1'b0);

        clear();
        push_exp();
        start = 1'b1;
        t0    = cyc;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (acc[0] >= 5) break;
        end
        chk("midrun_reached5", 64'(acc[0] >= 5), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrun_valid0", 64'(ov0), 64'd0);
        chk("midrun_busy0", 64'(busy0), 64'd0);
        chk("midrun_done0", 64'(done0), 64'd0);
        chk("midrun_valid1", 64'(ov1), 64'd0);
        chk("midrun_busy1", 64'(busy1), 64'd0);
        chk("midrun_no_done", 64'(done_n[0] + done_n[1]), 64'd0);
        rst = 1'b0;
        clear();
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_quiet", 64'(done_n[0] + done_n[1] + acc[0] + acc[1]), 64'd0);
        run(1'b0, -1, -1, 1'b1);

        run(1'b0, 4, 15, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fmap_window_streamer.md
# fmap_window_streamer

Parametrised inter-layer feeder: reads CH stored feature maps from the previous conv layer's result memories and streams KSIZE-row column vectors per channel into the next conv layer. It replaces the fixed 3-channel, 3-row, free-running streaming logic with pipelined reads and a valid/ready output. Output is backpressured through a small credit-tracked FIFO. The block sits between a layer's `done` and the next layer's `input_col_*`/`input_valid`.

## Interface
- `DATA_WIDTH`, 22, width of one stored result element
- `CH`, 3, number of feature-map channels
- `KSIZE`, 3, rows per column vector (odd, ≥1)
- `IMG_W`, 222, stored map width
- `IMG_H`, 222, stored map height (≥ KSIZE)
- `ADDR_WIDTH`, 18, memory address width
- `RD_LATENCY`, 1, memory read latency in cycles (≥1)

Ports:
- `clk` in 1 — the single clock.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — one-cycle request to stream a full map; ignored while `busy`.
- `busy` out 1 — high from the cycle after accepted `start` until `done`.
- `done` out 1 — one-cycle pulse after the last vector is accepted.
- `rd_en` out 1 — read strobe, common to all CH×KSIZE memory ports.
- `rd_addr` out KSIZE*ADDR_WIDTH — slot k (k=0 at MSB) is the row-k address, shared by all channels.
- `rd_data` in CH*KSIZE*DATA_WIDTH — slot (ch,k) returned data, same packing as `out_col`.
- `out_col` out CH*KSIZE*DATA_WIDTH — channel 0 most significant; within a channel row 0 most significant.
- `out_valid` out 1; `out_ready` in 1 — AXI-style handshake.
- `out_row`, `out_x` out ADDR_WIDTH each — output-row and column index of the vector on `out_col`.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE→RUN on `start`.
  - RUN→DRAIN after the last read is issued.
  - DRAIN→IDLE when the FIFO is empty and no reads are in flight; `done` pulses in that transition cycle.
- Scan order: output row r = 0..R-1 outer, column x = 0..IMG_W-1 inner.
  - Without padding, R = IMG_H-KSIZE+1.
  - Slot k address = (r+k)*IMG_W + x.
- Addresses are generated incrementally from per-slot row-base registers; no multipliers. Row base advances by IMG_W on column wrap.
- Read issue: `rd_en` is high in RUN when (FIFO occupancy + in-flight reads) < FIFO depth.
  - FIFO depth = RD_LATENCY+2.
  - In-flight reads are tracked by a RD_LATENCY-deep valid shift register.
- Returning data is written to the FIFO in the cycle its shift-register bit exits. `out_row`/`out_x` travel alongside it.
- Handshake: a vector is consumed when `out_valid && out_ready`.
  - `out_col`, `out_row`, `out_x` are held stable while `out_valid && !out_ready`.
- Simultaneous FIFO push and pop is legal at any occupancy, including full.
- `start` arriving in the same cycle as `done` is ignored.
- Reset outputs: `busy`=0, `done`=0, `rd_en`=0, `out_valid`=0, `rd_addr`=slot k → k*IMG_W, `out_col`=0, `out_row`=0, `out_x`=0.
- `rst` mid-operation: FIFO flushed, in-flight shift register cleared, next cycle in IDLE, no `done`. Returning data from discarded reads is ignored.

## Timing
- `start` sampled at edge 0: first `rd_en` in cycle 1.
- First `out_valid` in cycle 1+RD_LATENCY+1 (cycle 3 for RD_LATENCY=1).
- With `out_ready` held high: one vector per cycle sustained, no bubbles.
- Total run length = R*IMG_W + RD_LATENCY + 2 cycles from `start` to `done`.
- After `out_ready` deasserts, at most FIFO-depth vectors are buffered. No read is issued that would overflow the FIFO.

## Configuration
- `FMAP_STREAM_PAD_EN` defined: zero row padding is enabled.
  - R = IMG_H.
  - Slot k reads map row r+k-(KSIZE-1)/2.
  - Slots whose map row is <0 or ≥IMG_H yield zero in `out_col`. Their address is driven but their data is masked by a per-slot pad flag carried through the pipeline.
- `FMAP_STREAM_PAD_EN` undefined: no padding; pad-flag logic is absent.

## Test plan
- Base stream: CH=2, KSIZE=3, IMG_W=4, IMG_H=5, DW=8, RD_LATENCY=1.
  - Memory ch c returns (addr + 16c) mod 256; `start`, `out_ready`=1.
  - Expect 12 vectors. First vector is `out_col`={0,4,8,16,20,24}, `out_row`=0, `out_x`=0.
  - Last vector: `out_row`=2, `out_x`=3.
  - `done` at cycle 15 after `start`.
- Backpressure: same setup with `out_ready` toggled 1,0,0,1 repeating.
  - Every vector is delivered exactly once, in order.
  - Data is stable while stalled.
  - `rd_en` never causes occupancy >3.
- Latency sweep: rerun base test with RD_LATENCY=3.
  - First `out_valid` in cycle 5.
  - Identical vector sequence.
  - Full throughput with `out_ready`=1.
- Reset mid-run: assert `rst` after 5 accepted vectors.
  - Next cycle: `out_valid`=0, `busy`=0, no `done`.
  - A subsequent `start` yields the full 12-vector sequence from (0,0).
- Start while busy: pulse `start` at cycles 4 and 15.
  - Only one run of 12 vectors and one `done`.
- Padding with `FMAP_STREAM_PAD_EN` defined, base parameters:
  - 20 vectors.
  - Row 0 vector ch0 = {0,0,4}.
  - Row 4 vector ch0 = {12,16,0}.
